count_event_capture: RTL and testbench
======================================

// Module: count_event_capture
// PURPOSE
//  Timestamp capture stage downstream of the free-running 4-bit synchronous up counter.
//  Samples the counter value on each rising edge of an event input.
//  Extends the timestamp with an epoch (wrap) count.
//  Buffers timestamps in a small show-ahead FIFO, read out over a valid/ready handshake.
// PARAMETERS
//  CNT_W    4  width of incoming counter value cnt_q
//  EPOCH_W  4  width of wrap (epoch) counter prepended to timestamp
//  DEPTH    4  FIFO entries; power of 2, >= 2
// PORTS
//  clk       in   1                single clock; all state updates on posedge clk
//  r         in   1                reset, asynchronous, active-high
//  cnt_q     in   CNT_W            counter value, synchronous to clk
//  evt       in   1                event input; a 0->1 transition requests capture
//  ts_data   out  EPOCH_W+CNT_W    {epoch, count} at FIFO head; 0 when ts_valid=0
//  ts_valid  out  1                FIFO non-empty
//  ts_ready  in   1                consumer accepts head when ts_valid & ts_ready
//  level     out  $clog2(DEPTH)+1  current FIFO occupancy, 0..DEPTH
//  ovf       out  1                sticky: a capture was dropped because FIFO full
//  ovf_clr   in   1                synchronous clear of ovf
// BEHAVIOUR
//  - Reset (async assert, sync release): epoch=0, cnt_prev=0, evt_d=1, FIFO empty.
//    Outputs on reset: ts_valid=0, ts_data=0, level=0, ovf=0.
//  - Wrap detect: wrap = (cnt_q < cnt_prev); cnt_prev <= cnt_q every cycle.
//    On wrap, epoch <= epoch+1 mod 2^EPOCH_W.
//  - The cycle after reset never reports wrap: cnt_prev=0 and cnt_q < 0 is impossible.
//  - Edge detect: rise = evt & ~evt_d; evt_d <= evt every cycle.
//    evt_d resets to 1, so evt held high through reset produces no capture.
//  - Captured value: ts = {wrap ? epoch+1 : epoch, cnt_q}.
//    It is taken in the same cycle rise is seen, so a wrap-cycle event gets the new epoch.
//  - Push on rise. The entry is visible at the head 1 clk after the capturing edge if the FIFO was empty.
//  - Pop on ts_valid & ts_ready. Head advances and level decrements at that edge.
//  - Show-ahead: ts_data is always mem[rd_ptr] while ts_valid=1.
//  - Push and pop in the same cycle:
//    - FIFO not full: both happen, level unchanged.
//    - FIFO full: push accepted because a slot frees in the same cycle; no overflow.
//  - Push while full with no pop: capture dropped, FIFO contents unchanged, ovf <= 1.
//  - ovf_clr=1 clears ovf. If a drop happens in the same cycle, set wins and ovf stays 1.
//  - Pointers wrap modulo DEPTH. Full is detected by level==DEPTH, not by pointer equality.
//  - Reset mid-operation discards all FIFO contents and the epoch immediately.
//  - ts_valid is registered state; no combinational path from ts_ready to ts_valid.
// CONFIGURATION
//  EVT_SYNC_EN defined:
//    - evt passes through a 2-flop synchronizer (reset to 1) before edge detect.
//    - evt may be asynchronous to clk.
//    - Capture lands 2 clk later than without the macro.
//    - The captured cnt_q/epoch is the value in the cycle the synchronized edge is seen.
//  EVT_SYNC_EN undefined:
//    - evt feeds edge detect directly and must be synchronous to clk.
// TESTING
//  1 Reset with evt=1 held, release, hold 10 clk -> ts_valid=0, level=0, ovf=0.
//  2 cnt_q counting 0..15, evt pulses at cnt_q=3 and cnt_q=9, ts_ready=1
//    -> ts_data 8'h03 then 8'h09, each valid for 1 clk, 1 clk after capture.
//  3 cnt_q goes 15->0 (wrap), evt rises at that cnt_q=0 cycle -> ts_data=8'h10 (epoch 1, count 0).
//  4 ts_ready=0, 5 evt edges at cnt_q=1,3,5,7,9 -> level=4, ovf=1.
//    Then drain -> 8'h01,8'h03,8'h05,8'h07 in order.
//  5 FIFO full, evt edge with ts_ready=1 same cycle -> no ovf, level stays 4.
//    New entry appears last on drain.
//  6 ovf=1, ovf_clr=1 on a drop cycle -> ovf stays 1. ovf_clr=1 next cycle -> ovf=0.
//  7 Assert r mid-stream with level=3 -> ts_valid=0 and level=0 before next clk edge.
//    Epoch restarts at 0.

Source files
------------

// File: rtl/count_event_capture.sv
// rtl/count_event_capture.sv - event timestamp capture: {epoch, cnt_q} into a show-ahead FIFO
// Optional EVT_SYNC_EN: 2-flop synchronizer on evt ahead of edge detect.
module count_event_capture #(
    parameter int CNT_W   = 4,
    parameter int EPOCH_W = 4,
    parameter int DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        r,
    input  logic [CNT_W-1:0]            cnt_q,
    input  logic                        evt,
    output logic [EPOCH_W+CNT_W-1:0]    ts_data,
    output logic                        ts_valid,
    input  logic                        ts_ready,
    output logic [$clog2(DEPTH):0]      level,
    output logic                        ovf,
    input  logic                        ovf_clr
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int LVL_W = PTR_W + 1;
    localparam int TS_W  = EPOCH_W + CNT_W;

    logic                 evt_s;
    logic                 evt_d;
    logic [CNT_W-1:0]     cnt_prev;
    logic [EPOCH_W-1:0]   epoch;
    logic [EPOCH_W-1:0]   epoch_nxt;
    logic                 wrap;
    logic                 rise;
    logic [TS_W-1:0]      ts_in;

    logic [TS_W-1:0]      mem [DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level_q;
    logic                 full;
    logic                 push;
    logic                 pop;
    logic                 drop;

`ifdef EVT_SYNC_EN
    logic [1:0] evt_sync;

    // Reset to 1 so an evt already high at release is not seen as an edge.
    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            evt_sync <= 2'b11;
        end else begin
            evt_sync <= {evt_sync[0], evt};
        end
    end

    assign evt_s = evt_sync[1];
`else
    assign evt_s = evt;
`endif

    assign wrap      = (cnt_q < cnt_prev);
    assign rise      = evt_s & ~evt_d;
    assign epoch_nxt = epoch + EPOCH_W'(1);
    // A capture in the wrap cycle already belongs to the new epoch.
    assign ts_in     = {(wrap ? epoch_nxt : epoch), cnt_q};

    assign full = (level_q == LVL_W'(DEPTH));
    assign pop  = ts_valid & ts_ready;
    assign push = rise & (~full | pop);
    assign drop = rise & full & ~pop;

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            evt_d    <= 1'b1;
            cnt_prev <= '0;
            epoch    <= '0;
        end else begin
            evt_d    <= evt_s;
            cnt_prev <= cnt_q;
            if (wrap) begin
                epoch <= epoch_nxt;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= ts_in;
        end
    end

    always_ff @(posedge clk or posedge r) begin
        if (r) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            level_q <= '0;
            ovf     <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   level_q <= level_q + LVL_W'(1);
                2'b01:   level_q <= level_q - LVL_W'(1);
                default: level_q <= level_q;
            endcase
            // Set has priority over clear.
            if (drop) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
        end
    end

    assign ts_valid = (level_q != '0);
    assign ts_data  = ts_valid ? mem[rd_ptr] : '0;
    assign level    = level_q;

endmodule

// File: tb/tb_count_event_capture.sv
// tb/tb_count_event_capture.sv - directed self-checking bench for count_event_capture
module tb_count_event_capture;

    logic       clk = 1'b0;
    logic       r;
    logic [3:0] cnt_q;
    logic       evt;
    logic [7:0] ts_data;
    logic       ts_valid;
    logic       ts_ready;
    logic [2:0] level;
    logic       ovf;
    logic       ovf_clr;

    int checks   = 0;
    int failures = 0;

    count_event_capture #(.CNT_W(4), .EPOCH_W(4), .DEPTH(4)) dut (
        .clk      (clk),
        .r        (r),
        .cnt_q    (cnt_q),
        .evt      (evt),
        .ts_data  (ts_data),
        .ts_valid (ts_valid),
        .ts_ready (ts_ready),
        .level    (level),
        .ovf      (ovf),
        .ovf_clr  (ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        r        = 1'b1;
        evt      = 1'b1;
        cnt_q    = 4'd0;
        ts_ready = 1'b0;
        ovf_clr  = 1'b0;
        step();
        step();
        check("rst_valid", 16'(ts_valid), 16'd0);
        check("rst_data",  16'(ts_data),  16'd0);
        check("rst_level", 16'(level),    16'd0);
        check("rst_ovf",   16'(ovf),      16'd0);

        // evt held high through reset release must not capture
        r = 1'b0;
        repeat (10) step();
        check("hold_valid", 16'(ts_valid), 16'd0);
        check("hold_level", 16'(level),    16'd0);
        check("hold_ovf",   16'(ovf),      16'd0);

        // counting sweep with captures at 3 and 9
        ts_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            cnt_q = 4'(c);
            evt   = (c == 3 || c == 9);
            step();
            if (c == 3 || c == 9) begin
                check("sweep_valid", 16'(ts_valid), 16'd1);
                check("sweep_data",  16'(ts_data),  16'(c));
            end
            if (c == 4 || c == 10) begin
                check("sweep_popped", 16'(ts_valid), 16'd0);
            end
        end

        // capture in the wrap cycle takes the new epoch
        cnt_q = 4'd0;
        evt   = 1'b1;
        step();
        check("wrap_valid", 16'(ts_valid), 16'd1);
        check("wrap_data",  16'(ts_data),  16'h10);
        cnt_q = 4'd1;
        evt   = 1'b0;
        step();
        check("wrap_popped", 16'(ts_valid), 16'd0);

        r = 1'b1;
        step();
        r        = 1'b0;
        cnt_q    = 4'd0;
        ts_ready = 1'b0;

        // five edges into a 4-deep FIFO
        for (int c = 0; c <= 10; c++) begin
            cnt_q = 4'(c);
            evt   = (c % 2 == 1) && (c < 10);
            step();
            if (c == 7) begin
                check("fill_level4", 16'(level), 16'd4);
                check("fill_noovf",  16'(ovf),   16'd0);
            end
        end
        check("ovf_level", 16'(level), 16'd4);
        check("ovf_set",   16'(ovf),   16'd1);
        ts_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("drain_data", 16'(ts_data), 16'(1 + 2 * i));
            step();
        end
        check("drain_empty", 16'(level), 16'd0);
        ts_ready = 1'b0;
        ovf_clr  = 1'b1;
        step();
        ovf_clr  = 1'b0;
        check("ovf_cleared", 16'(ovf), 16'd0);

        // push while full with a simultaneous pop
        for (int c = 11; c <= 14; c++) begin
            cnt_q = 4'(c);
            evt   = 1'b1;
            step();
            evt   = 1'b0;
            step();
        end
        check("pp_full", 16'(level), 16'd4);
        cnt_q    = 4'd15;
        evt      = 1'b1;
        ts_ready = 1'b1;
        step();
        evt = 1'b0;
        check("pp_level", 16'(level),   16'd4);
        check("pp_ovf",   16'(ovf),     16'd0);
        check("pp_head",  16'(ts_data), 16'h0c);
        for (int v = 13; v <= 15; v++) begin
            step();
            check("pp_drain", 16'(ts_data), 16'(v));
        end
        step();
        check("pp_empty", 16'(ts_valid), 16'd0);
        ts_ready = 1'b0;

        // drop with ovf_clr in the same cycle: set wins
        for (int i = 0; i < 4; i++) begin
            evt = 1'b1;
            step();
            evt = 1'b0;
            step();
        end
        evt = 1'b1;
        step();
        check("drop_ovf",   16'(ovf),   16'd1);
        check("drop_level", 16'(level), 16'd4);
        evt = 1'b0;
        step();
        evt     = 1'b1;
        ovf_clr = 1'b1;
        step();
        check("clrset_ovf",   16'(ovf),     16'd1);
        check("clrset_level", 16'(level),   16'd4);
        check("clrset_head",  16'(ts_data), 16'h0f);
        evt = 1'b0;
        step();
        ovf_clr = 1'b0;
        check("clr_ovf", 16'(ovf), 16'd0);

        // reset mid-stream with level 3, after an epoch advance
        ts_ready = 1'b1;
        step();
        ts_ready = 1'b0;
        check("mid_level3", 16'(level), 16'd3);
        cnt_q = 4'd0;
        step();
        cnt_q = 4'd1;
        step();
        r = 1'b1;
        #1;
        check("mid_rst_valid", 16'(ts_valid), 16'd0);
        check("mid_rst_level", 16'(level),    16'd0);
        check("mid_rst_data",  16'(ts_data),  16'd0);
        step();
        r     = 1'b0;
        cnt_q = 4'd0;
        evt   = 1'b0;
        step();
        evt = 1'b1;
        step();
        check("epoch_restart_valid", 16'(ts_valid), 16'd1);
        check("epoch_restart_data",  16'(ts_data),  16'h00);
        check("epoch_restart_level", 16'(level),    16'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
